// File: rtl/mult_div_unit.sv
// Multi-cycle mult/div with HI/LO; Busy high MULT_LAT/DIV_LAT cycles, Start while Busy ignored, no other backpressure.
// Optional madd/maddu accumulate (MdOp 6/7) enabled by defining MDU_MADD_EN; otherwise those ops are no-ops.
module mult_div_unit #(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       MdOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MADDU = 3'd7;

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                load, commit, mt_hi, mt_lo;
   logic [2:0]          op_q;
   logic [WIDTH-1:0]    a_q, b_q, hi_q, lo_q;

   logic signed [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0]        prod_u;
   logic [2*WIDTH-1:0]        res;
   logic                      div_zero, div_ovf;
   logic [WIDTH-1:0]          safe_b;
   logic signed [WIDTH-1:0]   quo_s, rem_s;
   logic [WIDTH-1:0]          quo_u, rem_u;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      commit  = 1'b0;
      mt_hi   = 1'b0;
      mt_lo   = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               case (MdOp)
                  OP_MULT, OP_MULTU: begin
                     load    = 1'b1;
                     state_d = RUN;
                     cnt_d   = CW'(MULT_LAT - 1);
                  end
                  OP_DIV, OP_DIVU: begin
                     load    = 1'b1;
                     state_d = RUN;
                     cnt_d   = CW'(DIV_LAT - 1);
                  end
`ifdef MDU_MADD_EN
                  OP_MADD, OP_MADDU: begin
                     load    = 1'b1;
                     state_d = RUN;
                     cnt_d   = CW'(MULT_LAT - 1);
                  end
`endif
                  OP_MTHI: mt_hi = 1'b1;
                  OP_MTLO: mt_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               commit  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands are held in shadow registers; the result is formed from them only at commit.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (load) begin
            op_q <= MdOp;
            a_q  <= A;
            b_q  <= B;
         end
         if (mt_hi) hi_q <= A;
         if (mt_lo) lo_q <= A;
         if (commit) {hi_q, lo_q} <= res;
      end
   end

   assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
   assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

   // Corner cases get a harmless divisor so the shared divider never sees /0 or MIN/-1.
   assign div_zero = (b_q == '0);
   assign div_ovf  = (op_q == OP_DIV) && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
   assign safe_b   = (div_zero || div_ovf) ? WIDTH'(1) : b_q;
   assign quo_s    = $signed(a_q) / $signed(safe_b);
   assign rem_s    = $signed(a_q) % $signed(safe_b);
   assign quo_u    = a_q / safe_b;
   assign rem_u    = a_q % safe_b;

   always_comb begin
      res = {hi_q, lo_q};
      case (op_q)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV: begin
            if (div_zero)     res = {a_q, {WIDTH{1'b1}}};
            else if (div_ovf) res = {{WIDTH{1'b0}}, a_q};
            else              res = {rem_s, quo_s};
         end
         OP_DIVU: begin
            if (div_zero) res = {a_q, {WIDTH{1'b1}}};
            else          res = {rem_u, quo_u};
         end
`ifdef MDU_MADD_EN
         OP_MADD:  res = {hi_q, lo_q} + prod_s;
         OP_MADDU: res = {hi_q, lo_q} + prod_u;
`endif
         default: ;
      endcase
   end

   assign Busy = (state_q == RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected {latency, HI, LO} queued at issue, checked when Busy falls
// or one cycle after a non-busy op.
module tb_mult_div_unit;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        Start = 1'b0;
   logic [2:0]  MdOp  = 3'd0;
   logic [31:0] A     = '0;
   logic [31:0] B     = '0;
   logic        Busy;
   logic [31:0] HI, LO;

   typedef struct {
      int          lat;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   busy_cnt = 0;
   int   imm_req  = 0;
   int   imm_ack  = 0;

   mult_div_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .Start (Start),
      .MdOp  (MdOp),
      .A     (A),
      .B     (B),
      .Busy  (Busy),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: counts Busy cycles and compares HI/LO against the queue head on each response.
   always @(negedge Clock) begin
      exp_t e;
      if (!Reset) begin
         busy_cnt = 0;
         q.delete();
      end else if (Busy) begin
         busy_cnt++;
      end else if (busy_cnt > 0 || imm_req != imm_ack) begin
         if (q.size() == 0) begin
            check("unexpected_response", 64'(q.size()), 64'd1);
         end else begin
            e = q.pop_front();
            check("busy_len", 64'(busy_cnt), 64'(e.lat));
            check("hi", {32'd0, HI}, {32'd0, e.hi});
            check("lo", {32'd0, LO}, {32'd0, e.lo});
         end
         busy_cnt = 0;
         imm_ack  = imm_req;
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge Clock);
      #1;
      Start = 1'b1;
      MdOp  = op;
      A     = a;
      B     = b;
      @(posedge Clock);
      #1;
      Start = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] hi, input logic [31:0] lo);
      exp_t e;
      e.lat = lat;
      e.hi  = hi;
      e.lo  = lo;
      q.push_back(e);
      issue(op, a, b);
      if (lat == 0) imm_req++;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (q.size() == 0 && !Busy && imm_req == imm_ack) begin
            done = 1'b1;
            break;
         end
         @(negedge Clock);
      end
      if (!done) check("timeout_pending", 64'(q.size()), 64'd0);
   endtask

   initial begin
      repeat (3) @(posedge Clock);
      #1;
      check("reset_busy", {63'd0, Busy}, 64'd0);
      check("reset_hi", {32'd0, HI}, 64'd0);
      check("reset_lo", {32'd0, LO}, 64'd0);
      Reset = 1'b1;

      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA); wait_idle();
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001); wait_idle();
      run_op(3'd3, 32'd17, 32'd5, 10, 32'd2, 32'd3); wait_idle();
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD); wait_idle();
      run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD); wait_idle();
      run_op(3'd2, 32'h8000_0000, 32'd0, 10, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000); wait_idle();
      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h8000_0000, 32'd0); wait_idle();
      run_op(3'd3, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF); wait_idle();

      // mthi issued while the mult is busy must be dropped
      run_op(3'd0, 32'h100, 32'h100, 5, 32'd0, 32'h0001_0000);
      issue(3'd4, 32'h1234, 32'd0);
      wait_idle();

      run_op(3'd5, 32'h55, 32'd0, 0, 32'd0, 32'h55); wait_idle();
      run_op(3'd4, 32'hABCD, 32'd0, 0, 32'hABCD, 32'h55); wait_idle();

      // Reset in the middle of a div discards it and clears everything at once
      run_op(3'd2, 32'd100, 32'd7, 10, 32'd2, 32'd14);
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;
      #1;
      check("midrst_busy", {63'd0, Busy}, 64'd0);
      check("midrst_hi", {32'd0, HI}, 64'd0);
      check("midrst_lo", {32'd0, LO}, 64'd0);
      @(negedge Clock);
      @(posedge Clock);
      #1;
      Reset = 1'b1;

      run_op(3'd1, 32'd4, 32'd4, 5, 32'd0, 32'd16); wait_idle();
      run_op(3'd4, 32'd0, 32'd0, 0, 32'd0, 32'd16); wait_idle();
      run_op(3'd5, 32'hFFFF_FFFF, 32'd0, 0, 32'd0, 32'hFFFF_FFFF); wait_idle();
`ifdef MDU_MADD_EN
      run_op(3'd7, 32'd1, 32'd1, 5, 32'd1, 32'd0); wait_idle();
      run_op(3'd6, 32'hFFFF_FFFF, 32'd1, 5, 32'd0, 32'hFFFF_FFFF); wait_idle();
`else
      run_op(3'd7, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF); wait_idle();
      run_op(3'd6, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 32'hFFFF_FFFF); wait_idle();
`endif

      repeat (2) @(posedge Clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
